// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter/sequencer owning the select of a shared 3:1 datapath mux.
// Optional hold-limit preemption is compiled in with ARB_TIMEOUT_EN.
module mux3_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Reject configurations the hold counter cannot represent.
    if (MAX_HOLD < 2 || MAX_HOLD > 31 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_params
        $error("mux3_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    state_t     state, state_d;
    logic [1:0] ptr, ptr_d;
    logic [2:0] gnt_d;
    logic [1:0] sel_d;
    logic       busy_d;
    logic [1:0] win;
    logic       owner_req;

    // First requester found scanning p, p+1, p+2 (mod 3).
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] idx;
        case (p)
            2'd1:    idx = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd2:    idx = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: idx = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return idx;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             timeout_d;
    logic             other_req;
    assign other_req = |(req & ~gnt);
`endif

    assign owner_req = |(req & gnt);
    assign win       = pick(req, ptr);

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gnt_d   = gnt;
        sel_d   = sel;
        busy_d  = busy;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt;
        timeout_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d   = 3'b001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                if (cnt != CNT_W'(MAX_HOLD)) cnt_d = cnt + CNT_W'(1);
`endif
                // done and abort take precedence; preemption only when both are absent
                if (done || !owner_req) begin
                    gnt_d   = 3'b000;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(MAX_HOLD - 1) && other_req) begin
                    gnt_d     = 3'b000;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                gnt_d   = 3'b000;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            gnt   <= 3'b000;
            sel   <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            gnt   <= gnt_d;
            sel   <= sel_d;
            busy  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            timeout <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
